cpu_step_ctrl: RTL

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

---
 rtl/cpu_step_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// Run/halt/single-step controller that issues one-clk-wide cpu_en pulses.
// The board switches and the step button are synchronized and debounced here.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FAST_DIV        = 2097152,
    parameter int SLOW_DIV        = 536870912
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step,
    input  logic        sw_run,
    input  logic        sw_15,
    input  logic        halt_req,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic        halt_latched,
    output logic [15:0] step_cnt
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    localparam int              DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]     FAST_LAST = 32'(FAST_DIV - 1);
    localparam logic [31:0]     SLOW_LAST = 32'(SLOW_DIV - 1);

    logic [2:0]      r_meta;
    logic [2:0]      r_sync;
    logic            w_btn_s;
    logic            w_run_s;
    logic            w_sw15_s;
    logic            w_sw15_chg;

    logic [DB_W-1:0] r_db_cnt;
    logic            r_db_level;
    logic            r_db_prev;
    logic            w_step_req;

    state_t          r_state;
    state_t          w_state_next;
    logic [31:0]     r_rate_cnt;
    logic [31:0]     w_rate_next;
    logic [31:0]     w_div_last;
    logic            w_cpu_en_next;
    logic            r_cpu_en;
    logic            r_halt_latched;
    logic [15:0]     r_step_cnt;

    // Bit order: {sw_15, sw_run, btn_step}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {sw_15, sw_run, btn_step};
            r_sync <= r_meta;
        end
    end

    assign w_btn_s    = r_sync[0];
    assign w_run_s    = r_sync[1];
    assign w_sw15_s   = r_sync[2];
    // True in the cycle before the synchronized speed select takes its new value
    assign w_sw15_chg = r_meta[2] ^ r_sync[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
        end else begin
            r_db_prev <= r_db_level;
            if (w_btn_s == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_level <= w_btn_s;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    assign w_step_req = r_db_level & ~r_db_prev;

    always_comb begin
        w_state_next  = r_state;
        w_cpu_en_next = 1'b0;
        w_rate_next   = '0;
        w_div_last    = w_sw15_s ? SLOW_LAST : FAST_LAST;
        case (r_state)
            ST_HALT: begin
                if (w_run_s && !r_halt_latched && !halt_req) begin
                    w_state_next = ST_RUN;
                end else if (w_step_req) begin
                    w_state_next  = ST_STEP;
                    w_cpu_en_next = 1'b1;
                end
            end
            ST_RUN: begin
                // Leaving RUN also suppresses a pulse due this cycle
                if (!w_run_s || halt_req) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_cpu_en_next = (r_rate_cnt == w_div_last);
                    if (w_sw15_chg || (r_rate_cnt == w_div_last)) begin
                        w_rate_next = '0;
                    end else begin
                        w_rate_next = r_rate_cnt + 32'd1;
                    end
                end
            end
            ST_STEP: w_state_next = ST_HALT;
            default: w_state_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_HALT;
            r_cpu_en   <= 1'b0;
            r_rate_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cpu_en   <= w_cpu_en_next;
            r_rate_cnt <= w_rate_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halt_latched <= 1'b0;
            r_step_cnt     <= '0;
        end else begin
            if (!w_run_s) begin
                r_halt_latched <= 1'b0;
            end else if ((r_state == ST_RUN) && halt_req) begin
                r_halt_latched <= 1'b1;
            end
            if (w_cpu_en_next && (r_step_cnt != 16'hFFFF)) begin
                r_step_cnt <= r_step_cnt + 16'd1;
            end
        end
    end

    assign cpu_en       = r_cpu_en;
    assign state        = r_state;
    assign halt_latched = r_halt_latched;
    assign step_cnt     = r_step_cnt;

endmodule
